// File: rtl/vpu_pkg.sv
// Shared types for the VPU output path.
// row_t is one full row at the default lane count and element width.
package vpu_pkg;

    localparam int VPU_WIDTH_DEF  = 16;
    localparam int DATA_WIDTH_DEF = 32;

    typedef logic signed [VPU_WIDTH_DEF-1:0][DATA_WIDTH_DEF-1:0] row_t;

endpackage

// File: rtl/vpu_deskew_row_fifo.sv
// First-word-fall-through row FIFO.
// The head reads as zero while the FIFO is empty.
module row_fifo
    import vpu_pkg::*;
#(
    parameter type T     = row_t,
    parameter int  DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vpu_deskew.sv
// Re-aligns staggered VPU lanes into rows, flags partial slots,
// and buffers full rows for a valid/ready consumer.
module vpu_deskew
    import vpu_pkg::*;
#(
    parameter int VPU_WIDTH  = VPU_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic signed [VPU_WIDTH-1:0][DATA_WIDTH-1:0] dsk_data_in,
    input  logic [VPU_WIDTH-1:0]                      dsk_valid_in,
    input  logic                                      dsk_clear,
    output logic signed [VPU_WIDTH-1:0][DATA_WIDTH-1:0] row_data_out,
    output logic                                      row_valid_out,
    input  logic                                      row_ready_in,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]           fifo_count,
    output logic [15:0]                               rows_pushed,
    output logic                                      err_misalign,
    output logic                                      err_overflow
);

    typedef logic signed [VPU_WIDTH-1:0][DATA_WIDTH-1:0] lrow_t;

    logic [VPU_WIDTH-1:0] dly_valid;
    lrow_t                dly_data;
    logic [VPU_WIDTH-1:0] aligned_valid;
    lrow_t                aligned_data;

    // Lane j lags lane 0 by j cycles, so it needs VPU_WIDTH-1-j stages.
    for (genvar j = 0; j < VPU_WIDTH; j++) begin : g_lane
        localparam int N = VPU_WIDTH - 1 - j;
        if (N == 0) begin : g_pass
            assign dly_valid[j] = dsk_valid_in[j];
            assign dly_data[j]  = dsk_data_in[j];
        end else begin : g_dly
            logic [N-1:0]          v;
            logic [DATA_WIDTH-1:0] d [N];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v <= '0;
                    for (int k = 0; k < N; k++) d[k] <= '0;
                end else begin
                    v[0] <= dsk_valid_in[j];
                    if (dsk_valid_in[j]) d[0] <= dsk_data_in[j];
                    for (int k = 1; k < N; k++) begin
                        v[k] <= v[k-1];
                        if (v[k-1]) d[k] <= d[k-1];
                    end
                end
            end
            assign dly_valid[j] = v[N-1];
            assign dly_data[j]  = d[N-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aligned_valid <= '0;
            aligned_data  <= '0;
        end else begin
            aligned_valid <= dly_valid;
            aligned_data  <= dly_data;
        end
    end

    logic slot_full;
    logic slot_mixed;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic ovf_evt;

    assign slot_full  = &aligned_valid;
    assign slot_mixed = |aligned_valid && !slot_full;
    assign pop        = row_valid_out && row_ready_in;
    assign push       = slot_full && (!fifo_full || pop);
    assign ovf_evt    = slot_full && fifo_full && !pop;

    row_fifo #(
        .T     (lrow_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (aligned_data),
        .pop       (pop),
        .head      (row_data_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign row_valid_out = !fifo_empty;

    // Clear takes priority over any same-cycle event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_pushed  <= '0;
            err_misalign <= 1'b0;
            err_overflow <= 1'b0;
        end else if (dsk_clear) begin
            rows_pushed  <= '0;
            err_misalign <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (push)       rows_pushed  <= rows_pushed + 16'd1;
            if (slot_mixed) err_misalign <= 1'b1;
            if (ovf_evt)    err_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vpu_deskew.sv
// Randomized bench for vpu_deskew with a slot-level reference model.
module tb_vpu_deskew;

    localparam int W  = 4;
    localparam int DW = 32;
    localparam int D  = 4;
    localparam int NC = 4096;

    typedef logic [W-1:0][DW-1:0] row_b_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    row_b_t       dsk_data_in;
    logic [W-1:0] dsk_valid_in;
    logic         dsk_clear;
    row_b_t       row_data_out;
    logic         row_valid_out;
    logic         row_ready_in;
    logic [2:0]   fifo_count;
    logic [15:0]  rows_pushed;
    logic         err_misalign;
    logic         err_overflow;

    vpu_deskew #(
        .VPU_WIDTH  (W),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dsk_data_in   (dsk_data_in),
        .dsk_valid_in  (dsk_valid_in),
        .dsk_clear     (dsk_clear),
        .row_data_out  (row_data_out),
        .row_valid_out (row_valid_out),
        .row_ready_in  (row_ready_in),
        .fifo_count    (fifo_count),
        .rows_pushed   (rows_pushed),
        .err_misalign  (err_misalign),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle lane schedule: what each lane carries in each cycle.
    logic [W-1:0] sv [NC];
    row_b_t       sd [NC];

    row_b_t      m_q[$];
    row_b_t      obs[$];
    logic [15:0] m_rp;
    logic        m_mis;
    logic        m_ovf;
    int          tests = 0;
    int          fails = 0;

    task automatic sched_row(input int s, input row_b_t r, input int late);
        for (int j = 0; j < W; j++) begin
            int c;
            c = s + j + ((j == late) ? 1 : 0);
            sv[c][j] = 1'b1;
            sd[c][j] = r[j];
        end
    endtask

    function automatic row_b_t rand_row();
        row_b_t r;
        for (int j = 0; j < W; j++) r[j] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_rp  = '0;
        m_mis = 1'b0;
        m_ovf = 1'b0;
    endtask

    // One cycle: drive the schedule, then apply the slot rules at the edge.
    task automatic step();
        int n, s;
        logic [W-1:0] av;
        row_b_t ar;
        logic pop, full_row, do_push;
        n = cyc;
        dsk_valid_in = sv[n];
        dsk_data_in  = sd[n];
        s  = n - W;
        av = '0;
        ar = '0;
        if (s >= 0) begin
            for (int j = 0; j < W; j++) begin
                av[j] = sv[s+j][j];
                ar[j] = sd[s+j][j];
            end
        end
        pop      = (m_q.size() > 0) && row_ready_in;
        full_row = &av;
        do_push  = full_row && (m_q.size() < D || pop);
        if (row_valid_out && row_ready_in) obs.push_back(row_data_out);
        @(posedge clk);
        if (rst) begin
            if (pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(ar);
                m_rp = m_rp + 16'd1;
            end else if (full_row) begin
                m_ovf = 1'b1;
            end
            if (av != '0 && !full_row) m_mis = 1'b1;
            if (dsk_clear) begin
                m_rp  = '0;
                m_mis = 1'b0;
                m_ovf = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_clear();
        dsk_clear = 1'b1;
        step();
        dsk_clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if (row_valid_out !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", row_valid_out); end
        tests++; if (row_data_out !== '0) begin fails++; $display("FAIL rst_data: got %h want 0", row_data_out); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        tests++; if (rows_pushed !== 16'd0) begin fails++; $display("FAIL rst_rows: got %0d want 0", rows_pushed); end
        tests++; if (err_misalign !== 1'b0) begin fails++; $display("FAIL rst_mis: got %b want 0", err_misalign); end
        tests++; if (err_overflow !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b want 0", err_overflow); end
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_row();
        row_b_t r;
        int b;
        row_ready_in = 1'b1;
        for (int j = 0; j < W; j++) r[j] = 32'h100 + j;
        b = cyc + 2;
        sched_row(b, r, -1);
        repeat (10) begin
            step();
            tests++;
            if (row_valid_out !== (cyc == b + 5)) begin
                fails++;
                $display("FAIL single_valid cyc+%0d: got %b want %b", cyc - b, row_valid_out, cyc == b + 5);
            end
            if (cyc == b + 5) begin
                tests++;
                if (row_data_out !== r) begin fails++; $display("FAIL single_data: got %h want %h", row_data_out, r); end
            end
        end
        tests++; if (rows_pushed !== 16'd1) begin fails++; $display("FAIL single_rows: got %0d want 1", rows_pushed); end
    endtask

    task automatic test_stream();
        row_b_t sent[$];
        row_b_t r;
        int b, first, last, nv;
        row_ready_in = 1'b1;
        obs.delete();
        b = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < W; j++) r[j] = i * 16 + j;
            sent.push_back(r);
            sched_row(b + i, r, -1);
        end
        first = -1; last = -1; nv = 0;
        repeat (16) begin
            step();
            tests++; if (row_valid_out !== (m_q.size() > 0)) begin fails++; $display("FAIL stream_valid: got %b want %b", row_valid_out, m_q.size() > 0); end
            tests++; if (fifo_count > 3'd1) begin fails++; $display("FAIL stream_count: got %0d want <=1", fifo_count); end
            tests++; if (err_misalign !== 1'b0 || err_overflow !== 1'b0) begin fails++; $display("FAIL stream_err: got %b%b want 00", err_misalign, err_overflow); end
            if (row_valid_out) begin
                nv++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        tests++; if (nv != 8 || last - first != 7) begin fails++; $display("FAIL stream_contig: got %0d cycles span %0d want 8 span 7", nv, last - first); end
        tests++; if (obs.size() != 8) begin fails++; $display("FAIL stream_num: got %0d want 8", obs.size()); end
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            tests++; if (obs[i] !== sent[i]) begin fails++; $display("FAIL stream_row%0d: got %h want %h", i, obs[i], sent[i]); end
        end
    endtask

    task automatic test_overflow();
        row_b_t sent[$];
        row_b_t r;
        int b;
        do_clear();
        row_ready_in = 1'b0;
        b = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            r = rand_row();
            sent.push_back(r);
            sched_row(b + i, r, -1);
        end
        repeat (13) step();
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        tests++; if (err_overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
        tests++; if (rows_pushed !== 16'd4) begin fails++; $display("FAIL ovf_rows: got %0d want 4", rows_pushed); end
        obs.delete();
        row_ready_in = 1'b1;
        repeat (8) step();
        tests++; if (obs.size() != 4) begin fails++; $display("FAIL ovf_drain_num: got %0d want 4", obs.size()); end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            tests++; if (obs[i] !== sent[i]) begin fails++; $display("FAIL ovf_row%0d: got %h want %h", i, obs[i], sent[i]); end
        end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL ovf_empty: got %0d want 0", fifo_count); end
    endtask

    task automatic test_full_pop();
        row_b_t sent[$];
        row_b_t r;
        int b, s5;
        do_clear();
        row_ready_in = 1'b0;
        b = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            r = rand_row();
            sent.push_back(r);
            sched_row(b + i, r, -1);
        end
        repeat (10) step();
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL fp_fill: got %0d want 4", fifo_count); end
        obs.delete();
        s5 = cyc + 1;
        r = rand_row();
        sent.push_back(r);
        sched_row(s5, r, -1);
        repeat (W + 2) begin
            row_ready_in = (cyc == s5 + W);
            step();
        end
        row_ready_in = 1'b0;
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL fp_count: got %0d want 4", fifo_count); end
        tests++; if (err_overflow !== 1'b0) begin fails++; $display("FAIL fp_ovf: got %b want 0", err_overflow); end
        tests++; if (rows_pushed !== 16'd5) begin fails++; $display("FAIL fp_rows: got %0d want 5", rows_pushed); end
        row_ready_in = 1'b1;
        repeat (8) step();
        tests++; if (obs.size() != 5) begin fails++; $display("FAIL fp_num: got %0d want 5", obs.size()); end
        for (int i = 0; i < 5 && i < obs.size(); i++) begin
            tests++; if (obs[i] !== sent[i]) begin fails++; $display("FAIL fp_row%0d: got %h want %h", i, obs[i], sent[i]); end
        end
    endtask

    task automatic test_misalign();
        row_b_t ra, rb, rc;
        int b;
        do_clear();
        row_ready_in = 1'b1;
        obs.delete();
        ra = rand_row(); rb = rand_row(); rc = rand_row();
        b = cyc + 1;
        sched_row(b, ra, -1);
        sched_row(b + 1, rb, 2);
        sched_row(b + 3, rc, -1);
        repeat (14) step();
        tests++; if (err_misalign !== 1'b1) begin fails++; $display("FAIL mis_flag: got %b want 1", err_misalign); end
        tests++; if (rows_pushed !== 16'd2) begin fails++; $display("FAIL mis_rows: got %0d want 2", rows_pushed); end
        tests++; if (obs.size() != 2) begin fails++; $display("FAIL mis_num: got %0d want 2", obs.size()); end
        if (obs.size() == 2) begin
            tests++; if (obs[0] !== ra) begin fails++; $display("FAIL mis_rowa: got %h want %h", obs[0], ra); end
            tests++; if (obs[1] !== rc) begin fails++; $display("FAIL mis_rowc: got %h want %h", obs[1], rc); end
        end
        do_clear();
        tests++; if (err_misalign !== 1'b0) begin fails++; $display("FAIL mis_clr_flag: got %b want 0", err_misalign); end
        tests++; if (rows_pushed !== 16'd0) begin fails++; $display("FAIL mis_clr_rows: got %0d want 0", rows_pushed); end
    endtask

    task automatic test_random();
        do_clear();
        for (int k = 0; k < 220; k++) begin
            if (k < 180 && $urandom_range(0, 1) == 1)
                sched_row(cyc, rand_row(), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, W - 1)) : -1);
            row_ready_in = (k >= 190) || ($urandom_range(0, 2) != 0);
            dsk_clear    = ($urandom_range(0, 31) == 0);
            step();
            dsk_clear = 1'b0;
            tests++; if (row_valid_out !== (m_q.size() > 0)) begin fails++; $display("FAIL rnd_valid k=%0d: got %b want %b", k, row_valid_out, m_q.size() > 0); end
            tests++; if (fifo_count !== 3'(m_q.size())) begin fails++; $display("FAIL rnd_count k=%0d: got %0d want %0d", k, fifo_count, m_q.size()); end
            if (m_q.size() > 0) begin
                tests++; if (row_data_out !== m_q[0]) begin fails++; $display("FAIL rnd_data k=%0d: got %h want %h", k, row_data_out, m_q[0]); end
            end
            tests++; if (rows_pushed !== m_rp) begin fails++; $display("FAIL rnd_rows k=%0d: got %0d want %0d", k, rows_pushed, m_rp); end
            tests++; if (err_misalign !== m_mis) begin fails++; $display("FAIL rnd_mis k=%0d: got %b want %b", k, err_misalign, m_mis); end
            tests++; if (err_overflow !== m_ovf) begin fails++; $display("FAIL rnd_ovf k=%0d: got %b want %b", k, err_overflow, m_ovf); end
        end
    endtask

    task automatic test_reset_mid();
        int b;
        row_b_t r;
        row_ready_in = 1'b0;
        b = cyc + 1;
        for (int i = 0; i < 3; i++) sched_row(b + i, rand_row(), -1);
        repeat (6) step();
        tests++; if (fifo_count !== 3'(m_q.size())) begin fails++; $display("FAIL rm_pre: got %0d want %0d", fifo_count, m_q.size()); end
        #2 rst = 1'b0;
        #1;
        tests++; if (row_valid_out !== 1'b0) begin fails++; $display("FAIL rm_valid: got %b want 0", row_valid_out); end
        tests++; if (row_data_out !== '0) begin fails++; $display("FAIL rm_data: got %h want 0", row_data_out); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL rm_count: got %0d want 0", fifo_count); end
        tests++; if (rows_pushed !== 16'd0) begin fails++; $display("FAIL rm_rows: got %0d want 0", rows_pushed); end
        for (int i = 0; i < NC; i++) begin
            sv[i] = '0;
            sd[i] = '0;
        end
        model_clear();
        dsk_valid_in = '0;
        dsk_data_in  = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        row_ready_in = 1'b1;
        r = rand_row();
        b = cyc + 1;
        sched_row(b, r, -1);
        repeat (10) begin
            step();
            tests++;
            if (row_valid_out !== (cyc == b + 5)) begin
                fails++;
                $display("FAIL rm_lat cyc+%0d: got %b want %b", cyc - b, row_valid_out, cyc == b + 5);
            end
            if (cyc == b + 5) begin
                tests++;
                if (row_data_out !== r) begin fails++; $display("FAIL rm_row: got %h want %h", row_data_out, r); end
            end
        end
        tests++; if (err_misalign !== 1'b0) begin fails++; $display("FAIL rm_mis: got %b want 0", err_misalign); end
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            sv[i] = '0;
            sd[i] = '0;
        end
        model_clear();
        dsk_valid_in = '0;
        dsk_data_in  = '0;
        dsk_clear    = 1'b0;
        row_ready_in = 1'b0;
        test_reset();
        test_single_row();
        test_stream();
        test_overflow();
        test_full_pop();
        test_misalign();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vpu_deskew.md
Name: vpu_deskew

Overview:
- Sits downstream of the vector processing unit; the receiving end of its per-lane data/valid output bus.
- VPU lanes emerge staggered: lane j carries the element for a given output row exactly j cycles after lane 0.
- This block re-aligns the lanes into full rows, checks lane-valid consistency, and buffers the rows in a small FIFO.
- It presents each row to the output-buffer writer with a valid/ready handshake, because the array cannot be stalled.

Parameters:
- VPU_WIDTH, 16, number of lanes (must be ≥ 2).
- DATA_WIDTH, 32, signed element width per lane.
- FIFO_DEPTH, 4, row FIFO entries (power of 2, ≥ 2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- dsk_data_in  in  DATA_WIDTH x [VPU_WIDTH]  signed per-lane data from the VPU.
- dsk_valid_in  in  1 x [VPU_WIDTH]  per-lane valid from the VPU.
- dsk_clear  in  1  synchronous clear of the sticky error flags and the row counter.
- row_data_out  out  DATA_WIDTH x [VPU_WIDTH]  aligned row at the FIFO head.
- row_valid_out  out  1  FIFO non-empty.
- row_ready_in  in  1  consumer accepts the head row when it is high together with row_valid_out.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- rows_pushed  out  16  count of rows written into the FIFO, wraps at 2^16.
- err_misalign  out  1  sticky: an aligned slot had only some lanes valid.
- err_overflow  out  1  sticky: an aligned full row was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, asynchronous): all delay-line valids, aligned register, FIFO pointers, fifo_count, rows_pushed, err_* are 0. row_valid_out=0 and row_data_out=0.
- Delay lines: lane j is delayed by (VPU_WIDTH-1-j) registered stages, carrying both data and valid. Lane VPU_WIDTH-1 has zero stages. Data registers are written only when the associated valid is 1.
- Aligned stage: one register stage captures all delayed lanes, giving aligned_valid[j] and aligned_data[j].
- Slot classification, evaluated on each aligned cycle:
  - All aligned_valid=1: the slot is a full row and is pushed to the FIFO.
  - All aligned_valid=0: idle, nothing happens.
  - Mixed: the row is dropped and err_misalign is set. No push occurs.
- Latency: if lane 0 is sampled valid at edge t, with an empty FIFO row_valid_out rises after edge t+VPU_WIDTH (VPU_WIDTH delay/align stages), then the FIFO write. This gives VPU_WIDTH+1 cycles from the lane-0 sample to row visible. Back-to-back rows stream at 1 row/cycle.
- FIFO:
  - Push occurs when the slot is a full row and (count<FIFO_DEPTH or pop in the same cycle).
  - Pop occurs when row_valid_out && row_ready_in.
  - Simultaneous push and pop at full: both happen and the count is unchanged.
  - Simultaneous push and pop at empty: not possible, since head is invalid.
  - Push when full without a pop: the row is dropped, err_overflow is set, and pointers are unchanged.
- Output is first-word fall-through: row_data_out shows the head entry combinationally from the FIFO storage. It is stable while valid && !ready.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is exact from 0..FIFO_DEPTH.
- rows_pushed increments on each successful push and wraps from 0xFFFF to 0.
- dsk_clear=1 zeroes err_misalign, err_overflow and rows_pushed at the next edge. It does not flush the FIFO or the delay lines.
  - If an error event or push coincides with dsk_clear, clear wins: flags and counter read 0.
- Reset mid-stream discards all in-flight and buffered rows. Partial skewed rows arriving after reset release are classified normally and may raise err_misalign; that is accepted behaviour.
- No arithmetic is performed on data; values pass through bit-exact.

Decomposition:
- Shared package vpu_pkg contains:
  - VPU_WIDTH_DEF and DATA_WIDTH_DEF constants.
  - A typedef row_t, a packed array [VPU_WIDTH] of signed [DATA_WIDTH-1:0].
- Sub-module row_fifo: a parameterized first-word-fall-through synchronous FIFO of row_t. It has push/pop/full/empty/count ports and is reusable for the bias path.
- Delay lines and classification stay inline in vpu_deskew.

Test Plan (VPU_WIDTH=4, DATA_WIDTH=32, FIFO_DEPTH=4):
- Single row: lane j valid at cycle 10+j with data 0x100+j, ready=1 → row_valid_out high exactly at cycle 15 for one cycle, row = {0x100,0x101,0x102,0x103}, rows_pushed=1.
- Streaming: 8 consecutive skewed rows with data = row*16+lane, ready=1 → 8 consecutive valid cycles in order, fifo_count ≤ 1, no errors.
- Backpressure/overflow: ready=0, 6 rows → fifo_count=4, err_overflow=1, rows_pushed=4. Then ready=1 → rows 0..3 drain in order, and rows 4 and 5 never appear.
- Full with pop: FIFO full, ready pulsed exactly in the cycle a 5th row pushes → count stays 4, no overflow, and the 5th row is delivered last.
- Misalignment: lane 2 valid one cycle late for a row → err_misalign=1, no push, and the neighbouring correct rows are still delivered. Then dsk_clear → err_misalign=0 and rows_pushed=0.
- Async reset asserted mid-stream, between clock edges → all outputs 0 immediately. After release, a fresh skewed row is delivered with latency 5.
